// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the processor's single memory port between instruction fetch (IF)
// and data memory (DM). A request seen in IDLE is granted and its owner,
// address, write data and write enable are latched. The access then runs
// for LAT cycles. The read data is registered for the owner, and the owner
// gets a one-cycle acknowledge.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin between IF and DM
//                       undefined -> fixed priority, DM wins over IF
//
// Parameters:
//   N    address/data width
//   LAT  memory access cycles, 1..15
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   if_req/if_addr        fetch request (level) and address
//   if_ack/if_rdata       fetch completion pulse and registered read data
//   dm_req/dm_we          data request (level), 1 = write
//   dm_addr/dm_wdata      data address and write data
//   dm_ack/dm_rdata       data completion pulse and registered read data
//   mem_sel               port owner, 1 = DM, 0 = IF
//   mem_en/mem_we         memory enable / write strobe
//   mem_addr/mem_wdata    latched address / write data of the access
//   mem_rdata             memory read data, valid in last ACCESS cycle
//   busy                  high while an access or its response is in flight
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int N   = 64,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic         if_ack,
  output logic [N-1:0] if_rdata,
  input  logic         dm_req,
  input  logic         dm_we,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  output logic         dm_ack,
  output logic [N-1:0] dm_rdata,
  output logic         mem_sel,
  output logic         mem_en,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  output logic         busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // The counter counts down to 0, so the last ACCESS cycle is the one with cnt == 0
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         sel_q, sel_d;
  logic         we_q, we_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] if_rdata_q, if_rdata_d;
  logic [N-1:0] dm_rdata_q, dm_rdata_d;
  logic         any_req;
  logic         grant_dm;

  assign any_req = if_req | dm_req;

`ifdef ARB_ROUND_ROBIN_EN
  // last_if_q = 1 means IF got the last grant. After reset it is 0, which
  // means DM was last, so IF wins the first conflict.
  logic last_if_q, last_if_d;

  always_comb begin
    if (if_req && dm_req) grant_dm = last_if_q;
    else                  grant_dm = dm_req;
  end

  always_comb begin
    last_if_d = last_if_q;
    if (state_q == IDLE && any_req) last_if_d = ~grant_dm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_if_q <= 1'b0;
    else       last_if_q <= last_if_d;
  end
`else
  // DM wins any conflict. Otherwise the only requester is granted.
  assign grant_dm = dm_req;
`endif

  // Sequencer. Requests are sampled only in IDLE, and everything the memory
  // sees is latched at grant time, so requester inputs that change during
  // ACCESS have no effect.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
          sel_d   = grant_dm;
          we_d    = grant_dm & dm_we;
          addr_d  = grant_dm ? dm_addr : if_addr;
          wdata_d = grant_dm ? dm_wdata : '0;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          // DM writes leave dm_rdata untouched
          if (!sel_q)      if_rdata_d = mem_rdata;
          else if (!we_q)  dm_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // The write strobe is asserted only while the access is in progress
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & sel_q & we_q;
  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign if_ack    = (state_q == RESP) & ~sel_q;
  assign dm_ack    = (state_q == RESP) &  sel_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter (N=64, LAT=2). Runs a table of
// single transactions, a few hand-written multi-cycle sequences (contention,
// mid-access address change, reset during ACCESS, a dropped request) and a
// randomized run compared cycle by cycle against a timeline-based reference
// model. Follows ARB_ROUND_ROBIN_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int N   = 64;
  localparam int LAT = 2;

  logic         clk;
  logic         reset;
  logic         if_req;
  logic [N-1:0] if_addr;
  logic         if_ack;
  logic [N-1:0] if_rdata;
  logic         dm_req;
  logic         dm_we;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic         dm_ack;
  logic [N-1:0] dm_rdata;
  logic         mem_sel;
  logic         mem_en;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         is_dm;
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         exp_sel;
    logic         exp_we;
    logic [N-1:0] exp_addr;
    logic [N-1:0] exp_wdata;
    logic         exp_if_ack;
    logic         exp_dm_ack;
    logic [N-1:0] exp_if_rdata;
    logic [N-1:0] exp_dm_rdata;
  } vec_t;

  vec_t vecs[5];

  // Reference model state: one transaction at a time, described by how many
  // cycles have passed since its grant (age 1..LAT access, LAT+1 response).
  bit           m_active;
  int           m_age;
  bit           m_owner_dm;
  bit           m_we;
  logic [N-1:0] m_addr;
  logic [N-1:0] m_wdata;
  logic [N-1:0] m_if_rdata;
  logic [N-1:0] m_dm_rdata;
  bit           m_last_if;

  mem_port_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_sel   (mem_sel),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%b required=%b", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_if_ack"},     if_ack,    1'b0);
    checkBit({tag, "_dm_ack"},     dm_ack,    1'b0);
    checkBit({tag, "_mem_sel"},    mem_sel,   1'b0);
    checkBit({tag, "_mem_en"},     mem_en,    1'b0);
    checkBit({tag, "_mem_we"},     mem_we,    1'b0);
    checkBit({tag, "_busy"},       busy,      1'b0);
    checkOutput({tag, "_mem_addr"},  mem_addr,  '0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, '0);
    checkOutput({tag, "_if_rdata"},  if_rdata,  '0);
    checkOutput({tag, "_dm_rdata"},  dm_rdata,  '0);
  endtask

  task automatic modelReset();
    m_active   = 1'b0;
    m_age      = 0;
    m_owner_dm = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_if_rdata = '0;
    m_dm_rdata = '0;
    m_last_if  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    tick();
    tick();
    reset = 1'b0;
    modelReset();
  endtask

  // Advance the model across one clock edge using the inputs now applied
  task automatic modelStep();
    bit pick_dm;
    if (!m_active) begin
      if (if_req || dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_dm = (if_req && dm_req) ? m_last_if : dm_req;
`else
        pick_dm = dm_req;
`endif
        m_last_if  = !pick_dm;
        m_active   = 1'b1;
        m_age      = 1;
        m_owner_dm = pick_dm;
        m_we       = pick_dm && dm_we;
        m_addr     = pick_dm ? dm_addr : if_addr;
        m_wdata    = pick_dm ? dm_wdata : '0;
      end
    end else if (m_age == LAT) begin
      if (!m_owner_dm)  m_if_rdata = mem_rdata;
      else if (!m_we)   m_dm_rdata = mem_rdata;
      m_age = LAT + 1;
    end else if (m_age == LAT + 1) begin
      m_active = 1'b0;
      m_age    = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic modelCheck();
    bit exp_en;
    bit exp_resp;
    exp_en   = m_active && (m_age <= LAT);
    exp_resp = m_active && (m_age == LAT + 1);
    checkBit("rnd_mem_en",  mem_en,  exp_en);
    checkBit("rnd_busy",    busy,    m_active);
    checkBit("rnd_mem_sel", mem_sel, m_owner_dm);
    checkBit("rnd_mem_we",  mem_we,  exp_en && m_owner_dm && m_we);
    checkBit("rnd_if_ack",  if_ack,  exp_resp && !m_owner_dm);
    checkBit("rnd_dm_ack",  dm_ack,  exp_resp && m_owner_dm);
    checkOutput("rnd_mem_addr",  mem_addr,  m_addr);
    checkOutput("rnd_mem_wdata", mem_wdata, m_wdata);
    checkOutput("rnd_if_rdata",  if_rdata,  m_if_rdata);
    checkOutput("rnd_dm_rdata",  dm_rdata,  m_dm_rdata);
  endtask

  // Run one table transaction from IDLE to IDLE. Requester inputs are
  // scrambled after the grant, and mem_rdata holds the real data only in
  // the last ACCESS cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      if_addr = rnd64();
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      dm_we = 1'b1; dm_addr = rnd64(); dm_wdata = rnd64();
    end
    mem_rdata = rnd64();
    for (int c = 1; c <= LAT; c++) begin
      tick();
      checkBit({t, "_mem_en"},  mem_en,  1'b1);
      checkBit({t, "_busy"},    busy,    1'b1);
      checkBit({t, "_mem_sel"}, mem_sel, v.exp_sel);
      checkBit({t, "_mem_we"},  mem_we,  v.exp_we);
      checkOutput({t, "_mem_addr"},  mem_addr,  v.exp_addr);
      checkOutput({t, "_mem_wdata"}, mem_wdata, v.exp_wdata);
      checkBit({t, "_acc_if_ack"}, if_ack, 1'b0);
      checkBit({t, "_acc_dm_ack"}, dm_ack, 1'b0);
      if (v.is_dm) begin dm_addr = ~v.addr; dm_wdata = ~v.wdata; end
      else         if_addr = ~v.addr;
      mem_rdata = (c == LAT) ? v.rdata : rnd64();
    end
    tick();
    checkBit({t, "_if_ack"}, if_ack, v.exp_if_ack);
    checkBit({t, "_dm_ack"}, dm_ack, v.exp_dm_ack);
    checkBit({t, "_resp_en"}, mem_en, 1'b0);
    checkOutput({t, "_if_rdata"}, if_rdata, v.exp_if_rdata);
    checkOutput({t, "_dm_rdata"}, dm_rdata, v.exp_dm_rdata);
    if_req = 1'b0;
    dm_req = 1'b0;
    mem_rdata = rnd64();
    tick();
    checkBit({t, "_idle_busy"},   busy,   1'b0);
    checkBit({t, "_idle_if_ack"}, if_ack, 1'b0);
    checkBit({t, "_idle_dm_ack"}, dm_ack, 1'b0);
  endtask

  // Main test sequence
  initial begin
    vecs[0] = '{is_dm:1'b0, we:1'b0, addr:64'h100, wdata:64'h0, rdata:64'hDEAD_BEEF,
                exp_sel:1'b0, exp_we:1'b0, exp_addr:64'h100, exp_wdata:64'h0,
                exp_if_ack:1'b1, exp_dm_ack:1'b0,
                exp_if_rdata:64'hDEAD_BEEF, exp_dm_rdata:64'h0};
    vecs[1] = '{is_dm:1'b1, we:1'b1, addr:64'h40, wdata:64'h1234, rdata:64'h5555,
                exp_sel:1'b1, exp_we:1'b1, exp_addr:64'h40, exp_wdata:64'h1234,
                exp_if_ack:1'b0, exp_dm_ack:1'b1,
                exp_if_rdata:64'hDEAD_BEEF, exp_dm_rdata:64'h0};
    vecs[2] = '{is_dm:1'b1, we:1'b0, addr:64'h80, wdata:64'h77, rdata:64'hCAFE,
                exp_sel:1'b1, exp_we:1'b0, exp_addr:64'h80, exp_wdata:64'h77,
                exp_if_ack:1'b0, exp_dm_ack:1'b1,
                exp_if_rdata:64'hDEAD_BEEF, exp_dm_rdata:64'hCAFE};
    vecs[3] = '{is_dm:1'b0, we:1'b0, addr:64'h200, wdata:64'h0, rdata:64'h1111,
                exp_sel:1'b0, exp_we:1'b0, exp_addr:64'h200, exp_wdata:64'h0,
                exp_if_ack:1'b1, exp_dm_ack:1'b0,
                exp_if_rdata:64'h1111, exp_dm_rdata:64'hCAFE};
    vecs[4] = '{is_dm:1'b1, we:1'b1, addr:64'h10, wdata:64'hABCD, rdata:64'h9999,
                exp_sel:1'b1, exp_we:1'b1, exp_addr:64'h10, exp_wdata:64'hABCD,
                exp_if_ack:1'b0, exp_dm_ack:1'b1,
                exp_if_rdata:64'h1111, exp_dm_rdata:64'hCAFE};

    reset = 1'b1;
    clearInputs();
    doReset();
    checkAllZero("reset");

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Reset in the 2nd ACCESS cycle: everything clears at once, no ack,
    // and a still-held if_req starts a fresh full access afterwards.
    if_req  = 1'b1;
    if_addr = 64'h500;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkAllZero("midrst");
    tick();
    checkAllZero("midrst_hold");
    reset = 1'b0;
    modelReset();
    mem_rdata = rnd64();
    for (int c = 1; c <= LAT; c++) begin
      tick();
      checkBit("midrst_re_en", mem_en, 1'b1);
      checkOutput("midrst_re_addr", mem_addr, 64'h500);
      checkBit("midrst_re_ack", if_ack, 1'b0);
      mem_rdata = (c == LAT) ? 64'h600D : rnd64();
    end
    tick();
    checkBit("midrst_re_if_ack", if_ack, 1'b1);
    checkOutput("midrst_re_rdata", if_rdata, 64'h600D);
    if_req = 1'b0;

    // Both requests held: acks every LAT+2 cycles, owner by policy
    doReset();
    if_req = 1'b1; if_addr = 64'h300;
    dm_req = 1'b1; dm_addr = 64'h400; dm_we = 1'b0;
    for (int k = 1; k <= 3 * (LAT + 2); k++) begin
      bit ack_cycle;
      bit owner_dm;
      tick();
      ack_cycle = ((k % (LAT + 2)) == LAT + 1);
`ifdef ARB_ROUND_ROBIN_EN
      owner_dm = ((k / (LAT + 2)) % 2) == 1;
`else
      owner_dm = 1'b1;
`endif
      checkBit($sformatf("both_if_ack_c%0d", k), if_ack, ack_cycle && !owner_dm);
      checkBit($sformatf("both_dm_ack_c%0d", k), dm_ack, ack_cycle && owner_dm);
    end
    if_req = 1'b0;
    dm_req = 1'b0;

    // Address change during ACCESS is ignored; the next grant uses it
    doReset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h40;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      dm_addr = 64'h80;
      checkOutput("addrchg_hold", mem_addr, 64'h40);
    end
    checkBit("addrchg_ack", dm_ack, 1'b1);
    tick();
    checkBit("addrchg_idle", busy, 1'b0);
    tick();
    checkBit("addrchg_regrant_en", mem_en, 1'b1);
    checkOutput("addrchg_regrant_addr", mem_addr, 64'h80);
    dm_req = 1'b0;

    // Requester drops if_req during ACCESS: ack still arrives, then idle
    doReset();
    if_req = 1'b1; if_addr = 64'h700;
    tick();
    if_req = 1'b0;
    checkBit("drop_en_c1", mem_en, 1'b1);
    for (int k = 2; k <= LAT; k++) begin
      tick();
      checkBit("drop_en", mem_en, 1'b1);
    end
    tick();
    checkBit("drop_if_ack", if_ack, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkBit("drop_idle_busy", busy, 1'b0);
      checkBit("drop_idle_ack", if_ack, 1'b0);
    end

    // Randomized traffic against the reference model
    doReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if_req    = ($urandom_range(0, 3) != 0);
      dm_req    = ($urandom_range(0, 2) == 0);
      dm_we     = $urandom_range(0, 1) == 1;
      if_addr   = rnd64();
      dm_addr   = rnd64();
      dm_wdata  = rnd64();
      mem_rdata = rnd64();
      modelStep();
      tick();
      modelCheck();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
